// File: rtl/jump_pkg.sv
// Shared encodings for the branch/trap unit: operand selects, branch conditions,
// trap cause codes, machine CSR addresses and the controller state type.
package jump_pkg;

  localparam logic BASE_SRC_PC  = 1'b0;
  localparam logic BASE_SRC_RS1 = 1'b1;

  localparam logic [1:0] COND_NEVER    = 2'b00;
  localparam logic [1:0] COND_ALWAYS   = 2'b01;
  localparam logic [1:0] COND_EQ_ZERO  = 2'b10;
  localparam logic [1:0] COND_NEQ_ZERO = 2'b11;

  localparam logic [4:0] TRAP_INS_MISALIGN   = 5'd0;
  localparam logic [4:0] TRAP_ILLEGAL        = 5'd2;
  localparam logic [4:0] TRAP_EBREAK         = 5'd3;
  localparam logic [4:0] TRAP_LOAD_MISALIGN  = 5'd4;
  localparam logic [4:0] TRAP_STORE_MISALIGN = 5'd6;
  localparam logic [4:0] TRAP_ECALL          = 5'd11;

  localparam logic [4:0] IRQ_CAUSE_BASE = 5'd16;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } trap_state_t;

endpackage

// File: rtl/branch_trap_unit_if.sv
// Execute-stage bundle between the pipeline (master) and the branch/trap unit (slave).
interface branch_trap_unit_if #(
  parameter int XLEN = 32,
  parameter int NIRQ = 4
);
  logic            valid;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_rdata;
  logic            base_src;
  logic [1:0]      cond;
  logic            alu_zero;
  logic            ins_illegal;
  logic            ins_misalign;
  logic            ecall;
  logic            ebreak;
  logic            store_misalign;
  logic            load_misalign;
  logic [XLEN-1:0] bad_addr;
  logic            mret;
  logic [NIRQ-1:0] irq;
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic [XLEN-1:0] target;
  logic            taken;
  logic            flush;
  logic            stall;

  modport master (
    output valid, pc, imm, rs1_rdata, base_src, cond, alu_zero,
           ins_illegal, ins_misalign, ecall, ebreak, store_misalign, load_misalign,
           bad_addr, mret, irq, csr_we, csr_addr, csr_wdata,
    input  csr_rdata, target, taken, flush, stall
  );

  modport slave (
    input  valid, pc, imm, rs1_rdata, base_src, cond, alu_zero,
           ins_illegal, ins_misalign, ecall, ebreak, store_misalign, load_misalign,
           bad_addr, mret, irq, csr_we, csr_addr, csr_wdata,
    output csr_rdata, target, taken, flush, stall
  );
endinterface

// File: rtl/branch_trap_unit_trap_prio.sv
// Trap priority encoder: enabled interrupts beat every exception, lowest irq line wins,
// then exceptions in fixed machine-mode order.
module trap_prio
  import jump_pkg::*;
#(
  parameter int NIRQ = 4
) (
  input  logic            ins_illegal,
  input  logic            ins_misalign,
  input  logic            ecall,
  input  logic            ebreak,
  input  logic            store_misalign,
  input  logic            load_misalign,
  input  logic [NIRQ-1:0] irq,
  input  logic [NIRQ-1:0] irq_en,
  input  logic            mie,
  output logic            trap,
  output logic            is_irq,
  output logic [4:0]      cause
);

  logic [NIRQ-1:0] pend;

  always_comb begin
    pend   = irq & irq_en & {NIRQ{mie}};
    trap   = 1'b1;
    is_irq = 1'b0;
    cause  = '0;
    if (|pend) begin
      is_irq = 1'b1;
      // Descending scan so the lowest pending line is the last assignment.
      for (int i = NIRQ - 1; i >= 0; i--) begin
        if (pend[i]) cause = IRQ_CAUSE_BASE + 5'(i);
      end
    end else if (ins_illegal)    cause = TRAP_ILLEGAL;
    else if (ins_misalign)       cause = TRAP_INS_MISALIGN;
    else if (ecall)              cause = TRAP_ECALL;
    else if (ebreak)             cause = TRAP_EBREAK;
    else if (store_misalign)     cause = TRAP_STORE_MISALIGN;
    else if (load_misalign)      cause = TRAP_LOAD_MISALIGN;
    else                         trap  = 1'b0;
  end

endmodule

// File: rtl/branch_trap_unit.sv
// Execute-stage branch/jump redirect plus machine-mode trap controller (RUN/TRAP FSM,
// mstatus/mie/mtvec/mepc/mcause/mtval/mip CSRs, mret).
module branch_trap_unit
  import jump_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          NIRQ        = 4,
  parameter logic [63:0] MTVEC_RESET = 64'h0
) (
  input logic              clk,
  input logic              rst_n,
  branch_trap_unit_if.slave bus
);

  trap_state_t     state, next_state;
  logic            mstat_mie, mstat_mpie;
  logic [NIRQ-1:0] irq_en;
  logic [XLEN-1:0] mtvec, mepc, mcause, mtval;

  logic            trap_p, is_irq_p;
  logic [4:0]      cause_p;
  logic            exec, trap_take, commit;
  logic [XLEN-1:0] br_base, br_target, trap_vec;

  function automatic logic cond_hit(input logic [1:0] cond, input logic zero);
    case (cond)
      COND_ALWAYS:   return 1'b1;
      COND_EQ_ZERO:  return zero;
      COND_NEQ_ZERO: return !zero;
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] trap_value(input logic irq_trap, input logic [4:0] code,
                                                 input logic [XLEN-1:0] pc,
                                                 input logic [XLEN-1:0] bad);
    if (!irq_trap && (code == TRAP_INS_MISALIGN || code == TRAP_STORE_MISALIGN ||
                      code == TRAP_LOAD_MISALIGN))
      return bad;
    if (!irq_trap && code == TRAP_ILLEGAL) return pc;
    return '0;
  endfunction

  trap_prio #(.NIRQ(NIRQ)) u_prio (
    .ins_illegal   (bus.ins_illegal),
    .ins_misalign  (bus.ins_misalign),
    .ecall         (bus.ecall),
    .ebreak        (bus.ebreak),
    .store_misalign(bus.store_misalign),
    .load_misalign (bus.load_misalign),
    .irq           (bus.irq),
    .irq_en        (irq_en),
    .mie           (mstat_mie),
    .trap          (trap_p),
    .is_irq        (is_irq_p),
    .cause         (cause_p)
  );

  assign exec      = bus.valid && (state == ST_RUN);
  assign trap_take = exec && trap_p;
  assign commit    = exec && !trap_p;
  assign br_base   = (bus.base_src == BASE_SRC_RS1) ? bus.rs1_rdata : bus.pc;
  assign br_target = br_base + bus.imm;
  // Vectored mode only offsets interrupts; the offset is 4 x the low cause code.
  assign trap_vec  = {mtvec[XLEN-1:2], 2'b00} +
                     (((mtvec[1:0] == 2'b01) && mcause[XLEN-1]) ? {mcause[XLEN-3:0], 2'b00}
                                                                : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    bus.taken  = 1'b0;
    bus.flush  = 1'b0;
    bus.stall  = 1'b0;
    bus.target = br_target;
    case (state)
      ST_RUN: begin
        if (trap_take) begin
          bus.flush  = 1'b1;
          bus.stall  = 1'b1;
          next_state = ST_TRAP;
        end else if (commit && bus.mret) begin
          bus.taken  = 1'b1;
          bus.target = mepc;
        end else if (commit) begin
          bus.taken  = cond_hit(bus.cond, bus.alu_zero);
        end
      end
      ST_TRAP: begin
        bus.taken  = 1'b1;
        bus.target = trap_vec;
        next_state = ST_RUN;
      end
      default: next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstat_mie  <= 1'b0;
      mstat_mpie <= 1'b0;
      irq_en     <= '0;
      mtvec      <= MTVEC_RESET[XLEN-1:0];
      mepc       <= '0;
      mcause     <= '0;
      mtval      <= '0;
    end else if (trap_take) begin
      mepc       <= {bus.pc[XLEN-1:2], 2'b00};
      mcause     <= {is_irq_p, {(XLEN-6){1'b0}}, cause_p};
      mtval      <= trap_value(is_irq_p, cause_p, bus.pc, bus.bad_addr);
      mstat_mpie <= mstat_mie;
      mstat_mie  <= 1'b0;
    end else if (commit) begin
      if (bus.csr_we) begin
        case (bus.csr_addr)
          CSR_MSTATUS: begin
            mstat_mie  <= bus.csr_wdata[3];
            mstat_mpie <= bus.csr_wdata[7];
          end
          CSR_MIE:    irq_en <= bus.csr_wdata[16 +: NIRQ];
          CSR_MTVEC:  mtvec  <= bus.csr_wdata;
          CSR_MEPC:   mepc   <= {bus.csr_wdata[XLEN-1:2], 2'b00};
          CSR_MCAUSE: mcause <= bus.csr_wdata;
          CSR_MTVAL:  mtval  <= bus.csr_wdata;
          default: ;
        endcase
      end
      // mret's mstatus update takes precedence over a same-cycle mstatus write.
      if (bus.mret) begin
        mstat_mie  <= mstat_mpie;
        mstat_mpie <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.csr_rdata = '0;
    case (bus.csr_addr)
      CSR_MSTATUS: begin
        bus.csr_rdata[3] = mstat_mie;
        bus.csr_rdata[7] = mstat_mpie;
      end
      CSR_MIE:    bus.csr_rdata[16 +: NIRQ] = irq_en;
      CSR_MTVEC:  bus.csr_rdata = mtvec;
      CSR_MEPC:   bus.csr_rdata = mepc;
      CSR_MCAUSE: bus.csr_rdata = mcause;
      CSR_MTVAL:  bus.csr_rdata = mtval;
      CSR_MIP:    bus.csr_rdata[16 +: NIRQ] = bus.irq;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_branch_trap_unit.sv
// Directed bench for branch_trap_unit: branches, trap entry/priority, vectored irq, mret, reset.
module tb_branch_trap_unit;
  import jump_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  branch_trap_unit_if #(.XLEN(32), .NIRQ(4)) bus ();

  branch_trap_unit #(.XLEN(32), .NIRQ(4), .MTVEC_RESET(64'h0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic idle();
    bus.valid = 0; bus.pc = '0; bus.imm = '0; bus.rs1_rdata = '0;
    bus.base_src = BASE_SRC_PC; bus.cond = COND_NEVER; bus.alu_zero = 0;
    bus.ins_illegal = 0; bus.ins_misalign = 0; bus.ecall = 0; bus.ebreak = 0;
    bus.store_misalign = 0; bus.load_misalign = 0; bus.bad_addr = '0; bus.mret = 0;
    bus.irq = '0; bus.csr_we = 0; bus.csr_addr = '0; bus.csr_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    bus.valid = 1; bus.csr_we = 1; bus.csr_addr = addr; bus.csr_wdata = data;
    step();
    idle();
  endtask

  task automatic csr_read(input logic [11:0] addr, output logic [31:0] data);
    bus.csr_addr = addr;
    #1 data = bus.csr_rdata;
  endtask

  // flags = {ins_illegal, ins_misalign, ecall, ebreak, store_misalign, load_misalign}
  task automatic run_trap(input logic [5:0] flags, input logic [31:0] pc,
                          input logic [31:0] bad);
    bus.valid = 1; bus.pc = pc; bus.bad_addr = bad;
    {bus.ins_illegal, bus.ins_misalign, bus.ecall, bus.ebreak,
     bus.store_misalign, bus.load_misalign} = flags;
    step();
    idle();
    step();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    #1;
    tests_run++; if ({bus.taken, bus.flush, bus.stall} !== 3'b000) begin tests_failed++;
      $display("FAIL reset_outputs: got %b exp 000", {bus.taken, bus.flush, bus.stall}); end
    csr_read(CSR_MTVEC, v);
    tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL reset_mtvec: got %h exp 0", v); end
    csr_read(CSR_MSTATUS, v);
    tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL reset_mstatus: got %h exp 0", v); end
    csr_read(CSR_MCAUSE, v);
    tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL reset_mcause: got %h exp 0", v); end
  endtask

  task automatic test_branch();
    bus.valid = 1; bus.cond = COND_EQ_ZERO; bus.alu_zero = 1; bus.pc = 32'h100; bus.imm = 32'h20;
    #1;
    tests_run++; if ({bus.taken, bus.flush} !== 2'b10 || bus.target !== 32'h120) begin tests_failed++;
      $display("FAIL br_eq_zero: got taken/flush %b target %h exp 10 00000120", {bus.taken, bus.flush}, bus.target); end
    bus.cond = COND_NEQ_ZERO;
    #1;
    tests_run++; if (bus.taken !== 1'b0) begin tests_failed++; $display("FAIL br_neq_zero: got %b exp 0", bus.taken); end
    bus.cond = COND_ALWAYS; bus.base_src = BASE_SRC_RS1; bus.rs1_rdata = 32'h4000; bus.imm = 32'hFFFF_FFFC;
    #1;
    tests_run++; if (bus.taken !== 1'b1 || bus.target !== 32'h3FFC) begin tests_failed++;
      $display("FAIL br_rs1: got %b %h exp 1 00003ffc", bus.taken, bus.target); end
    bus.base_src = BASE_SRC_PC; bus.pc = 32'hFFFF_FFF0; bus.imm = 32'h20;
    #1;
    tests_run++; if (bus.target !== 32'h10) begin tests_failed++; $display("FAIL br_wrap: got %h exp 00000010", bus.target); end
    bus.cond = COND_NEVER;
    #1;
    tests_run++; if (bus.taken !== 1'b0) begin tests_failed++; $display("FAIL br_never: got %b exp 0", bus.taken); end
    bus.cond = COND_ALWAYS; bus.valid = 0;
    #1;
    tests_run++; if (bus.taken !== 1'b0) begin tests_failed++; $display("FAIL br_invalid: got %b exp 0", bus.taken); end
    idle();
    step();
  endtask

  task automatic test_ecall();
    logic [31:0] v;
    csr_write(CSR_MTVEC, 32'h1000);
    bus.valid = 1; bus.ecall = 1; bus.pc = 32'h200; bus.cond = COND_ALWAYS;
    #1;
    tests_run++; if ({bus.taken, bus.flush, bus.stall} !== 3'b011) begin tests_failed++;
      $display("FAIL ecall_cycle_n: got t/f/s %b exp 011", {bus.taken, bus.flush, bus.stall}); end
    step();
    bus.ecall = 0;
    #1;
    tests_run++; if ({bus.taken, bus.flush, bus.stall} !== 3'b100 || bus.target !== 32'h1000) begin tests_failed++;
      $display("FAIL ecall_cycle_n1: got t/f/s %b target %h exp 100 00001000", {bus.taken, bus.flush, bus.stall}, bus.target); end
    idle();
    step();
    tests_run++; if (bus.taken !== 1'b0) begin tests_failed++; $display("FAIL ecall_back_run: got %b exp 0", bus.taken); end
    csr_read(CSR_MCAUSE, v);
    tests_run++; if (v !== 32'd11) begin tests_failed++; $display("FAIL ecall_mcause: got %h exp 0000000b", v); end
    csr_read(CSR_MEPC, v);
    tests_run++; if (v !== 32'h200) begin tests_failed++; $display("FAIL ecall_mepc: got %h exp 00000200", v); end
    csr_read(CSR_MSTATUS, v);
    tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL ecall_mstatus: got %h exp 0", v); end
    csr_read(CSR_MTVAL, v);
    tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL ecall_mtval: got %h exp 0", v); end
  endtask

  task automatic test_irq_vs_exception();
    logic [31:0] v;
    csr_write(CSR_MSTATUS, 32'h8);
    csr_write(CSR_MIE, 32'h0001_0000);
    csr_write(CSR_MTVEC, 32'h1001);
    bus.valid = 1; bus.irq = 4'b0001; bus.ins_illegal = 1; bus.pc = 32'h300;
    #1;
    tests_run++; if (bus.flush !== 1'b1) begin tests_failed++; $display("FAIL irq_flush: got %b exp 1", bus.flush); end
    step();
    idle();
    #1;
    tests_run++; if (bus.taken !== 1'b1 || bus.target !== 32'h1040) begin tests_failed++;
      $display("FAIL irq_vector: got %b %h exp 1 00001040", bus.taken, bus.target); end
    step();
    csr_read(CSR_MCAUSE, v);
    tests_run++; if (v !== 32'h8000_0010) begin tests_failed++; $display("FAIL irq_mcause: got %h exp 80000010", v); end
    csr_read(CSR_MEPC, v);
    tests_run++; if (v !== 32'h300) begin tests_failed++; $display("FAIL irq_mepc: got %h exp 00000300", v); end
    csr_read(CSR_MSTATUS, v);
    tests_run++; if (v !== 32'h80) begin tests_failed++; $display("FAIL irq_mstatus: got %h exp 00000080", v); end
    csr_read(CSR_MTVAL, v);
    tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL irq_mtval: got %h exp 0", v); end
  endtask

  task automatic test_mret();
    logic [31:0] v;
    csr_write(CSR_MEPC, 32'h204);
    bus.valid = 1; bus.mret = 1; bus.csr_we = 1; bus.csr_addr = CSR_MEPC; bus.csr_wdata = 32'h999;
    #1;
    tests_run++; if (bus.taken !== 1'b1 || bus.target !== 32'h204 || bus.flush !== 1'b0) begin tests_failed++;
      $display("FAIL mret_redirect: got %b %h flush %b exp 1 00000204 0", bus.taken, bus.target, bus.flush); end
    step();
    idle();
    csr_read(CSR_MSTATUS, v);
    tests_run++; if (v !== 32'h88) begin tests_failed++; $display("FAIL mret_mstatus: got %h exp 00000088", v); end
    csr_read(CSR_MEPC, v);
    tests_run++; if (v !== 32'h998) begin tests_failed++; $display("FAIL mret_mepc_write: got %h exp 00000998", v); end
  endtask

  task automatic test_store_misalign();
    logic [31:0] v;
    bus.valid = 1; bus.store_misalign = 1; bus.bad_addr = 32'h3003; bus.pc = 32'h400;
    bus.csr_we = 1; bus.csr_addr = CSR_MTVEC; bus.csr_wdata = 32'h5555;
    #1;
    tests_run++; if (bus.flush !== 1'b1) begin tests_failed++; $display("FAIL sm_flush: got %b exp 1", bus.flush); end
    step();
    idle();
    #1;
    tests_run++; if (bus.taken !== 1'b1 || bus.target !== 32'h1000) begin tests_failed++;
      $display("FAIL sm_target: got %b %h exp 1 00001000", bus.taken, bus.target); end
    step();
    csr_read(CSR_MTVAL, v);
    tests_run++; if (v !== 32'h3003) begin tests_failed++; $display("FAIL sm_mtval: got %h exp 00003003", v); end
    csr_read(CSR_MTVEC, v);
    tests_run++; if (v !== 32'h1001) begin tests_failed++; $display("FAIL sm_mtvec_kept: got %h exp 00001001", v); end
    csr_read(CSR_MCAUSE, v);
    tests_run++; if (v !== 32'd6) begin tests_failed++; $display("FAIL sm_mcause: got %h exp 00000006", v); end
    csr_read(CSR_MSTATUS, v);
    tests_run++; if (v !== 32'h80) begin tests_failed++; $display("FAIL sm_mstatus: got %h exp 00000080", v); end
  endtask

  task automatic test_priority();
    logic [31:0] v;
    run_trap(6'b101000, 32'h500, 32'h0);
    csr_read(CSR_MCAUSE, v);
    tests_run++; if (v !== 32'd2) begin tests_failed++; $display("FAIL prio_illegal_cause: got %h exp 00000002", v); end
    csr_read(CSR_MTVAL, v);
    tests_run++; if (v !== 32'h500) begin tests_failed++; $display("FAIL prio_illegal_mtval: got %h exp 00000500", v); end
    run_trap(6'b001101, 32'h540, 32'h777);
    csr_read(CSR_MCAUSE, v);
    tests_run++; if (v !== 32'd11) begin tests_failed++; $display("FAIL prio_ecall_cause: got %h exp 0000000b", v); end
    csr_read(CSR_MTVAL, v);
    tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL prio_ecall_mtval: got %h exp 0", v); end
    run_trap(6'b010100, 32'h600, 32'h601);
    csr_read(CSR_MCAUSE, v);
    tests_run++; if (v !== 32'd0) begin tests_failed++; $display("FAIL prio_imis_cause: got %h exp 0", v); end
    csr_read(CSR_MTVAL, v);
    tests_run++; if (v !== 32'h601) begin tests_failed++; $display("FAIL prio_imis_mtval: got %h exp 00000601", v); end
    run_trap(6'b000011, 32'h640, 32'h641);
    csr_read(CSR_MCAUSE, v);
    tests_run++; if (v !== 32'd6) begin tests_failed++; $display("FAIL prio_store_cause: got %h exp 00000006", v); end
    run_trap(6'b000001, 32'h680, 32'h682);
    csr_read(CSR_MCAUSE, v);
    tests_run++; if (v !== 32'd4) begin tests_failed++; $display("FAIL prio_load_cause: got %h exp 00000004", v); end
  endtask

  task automatic test_irq_mask_and_index();
    logic [31:0] v;
    csr_write(CSR_MSTATUS, 32'h8);
    csr_write(CSR_MIE, 32'h000C_0000);
    csr_read(CSR_MIE, v);
    tests_run++; if (v !== 32'h000C_0000) begin tests_failed++; $display("FAIL mie_read: got %h exp 000c0000", v); end
    bus.irq = 4'b0101;
    csr_read(CSR_MIP, v);
    tests_run++; if (v !== 32'h0005_0000) begin tests_failed++; $display("FAIL mip_read: got %h exp 00050000", v); end
    bus.valid = 1; bus.irq = 4'b0001;
    #1;
    tests_run++; if (bus.flush !== 1'b0) begin tests_failed++; $display("FAIL irq_masked: got %b exp 0", bus.flush); end
    bus.irq = 4'b1100; bus.pc = 32'h700;
    #1;
    tests_run++; if (bus.flush !== 1'b1) begin tests_failed++; $display("FAIL irq2_flush: got %b exp 1", bus.flush); end
    step();
    idle();
    #1;
    tests_run++; if (bus.target !== 32'h1048 || bus.taken !== 1'b1) begin tests_failed++;
      $display("FAIL irq2_vector: got %b %h exp 1 00001048", bus.taken, bus.target); end
    step();
    csr_read(CSR_MCAUSE, v);
    tests_run++; if (v !== 32'h8000_0012) begin tests_failed++; $display("FAIL irq2_mcause: got %h exp 80000012", v); end
    csr_write(12'h7C0, 32'hFFFF_FFFF);
    csr_read(12'h7C0, v);
    tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL unknown_csr: got %h exp 0", v); end
  endtask

  task automatic test_reset_in_trap();
    logic [31:0] v;
    bus.valid = 1; bus.ecall = 1; bus.pc = 32'h800;
    step();
    idle();
    rst_n = 0;
    #1;
    tests_run++; if ({bus.taken, bus.flush, bus.stall} !== 3'b000) begin tests_failed++;
      $display("FAIL rst_trap_outputs: got t/f/s %b exp 000", {bus.taken, bus.flush, bus.stall}); end
    csr_read(CSR_MTVEC, v);
    tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL rst_trap_mtvec: got %h exp 0", v); end
    csr_read(CSR_MEPC, v);
    tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL rst_trap_mepc: got %h exp 0", v); end
    csr_read(CSR_MCAUSE, v);
    tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL rst_trap_mcause: got %h exp 0", v); end
    csr_read(CSR_MTVAL, v);
    tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL rst_trap_mtval: got %h exp 0", v); end
    csr_read(CSR_MSTATUS, v);
    tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL rst_trap_mstatus: got %h exp 0", v); end
    csr_read(CSR_MIE, v);
    tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL rst_trap_mie: got %h exp 0", v); end
    step();
    rst_n = 1;
    step();
    tests_run++; if (bus.taken !== 1'b0) begin tests_failed++; $display("FAIL rst_trap_after: got %b exp 0", bus.taken); end
  endtask

  initial begin
    idle();
    rst_n = 0;
    step();
    step();
    test_reset();
    rst_n = 1;
    step();
    test_branch();
    test_ecall();
    test_irq_vs_exception();
    test_mret();
    test_store_misalign();
    test_priority();
    test_irq_mask_and_index();
    test_reset_in_trap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/branch_trap_unit.md
# branch_trap_unit

Parametrised successor to the combinational jump unit: computes branch/jump targets and the taken decision, and adds a sequential machine-mode trap controller. The controller prioritises exceptions and interrupts, latches mepc/mcause/mtval, keeps mstatus.MIE/MPIE, supports direct and vectored mtvec, and handles mret. It sits in the execute stage, alongside the ALU, and drives the fetch redirect and pipeline flush.

## Interface
- XLEN, 32: datapath width (32 or 64)
- NIRQ, 4: interrupt lines, 1..16
- MTVEC_RESET, 0: reset value of mtvec
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid  in  1  execute-stage instruction present, not stalled
- pc, imm, rs1_rdata  in  XLEN  target operands
- base_src  in  1  BASE_SRC_RS1 selects rs1_rdata, else pc
- cond  in  2  COND_NEVER/ALWAYS/EQ_ZERO/NEQ_ZERO
- alu_zero  in  1  ALU result zero
- ins_illegal, ins_misalign, ecall, ebreak, store_misalign, load_misalign  in  1 each  exception flags
- bad_addr  in  XLEN  faulting address for mtval
- mret  in  1  instruction is mret
- irq  in  NIRQ  level-sensitive interrupt requests
- csr_we  in  1; csr_addr  in  12; csr_wdata  in  XLEN  CSR write port
- csr_rdata  out  XLEN  combinational read of csr_addr
- target  out  XLEN  redirect address
- taken  out  1  redirect fetch to target this cycle
- flush  out  1  kill execute-stage instruction and younger
- stall  out  1  hold the pipeline

## Operation
- Normal target is base + imm, computed modulo 2^XLEN. The normal taken decision follows the cond encoding of the existing jump unit. Both are qualified by valid, state RUN, and no trap.
- The unit owns these CSRs, at standard addresses:
  - mstatus: only MIE (bit 3) and MPIE (bit 7); other bits read 0.
  - mie: bits 16+i.
  - mtvec.
  - mepc: bits [1:0] read 0.
  - mcause.
  - mtval.
  - mip: read-only, bit 16+i = irq[i].
- Unknown csr_addr reads 0 and ignores writes.
- An interrupt is pending when irq[i] & mie[16+i] & MIE. The lowest i wins.
- Trap evaluation occurs in RUN when valid=1.
- Trap priority: interrupt, then ins_illegal(2), ins_misalign(0), ecall(11), ebreak(3), store_misalign(6), load_misalign(4).
- On trap entry:
  - mepc ← pc.
  - mcause ← code. For an interrupt, bit XLEN-1 is set and the code is 16+i.
  - mtval ← bad_addr for misaligned exceptions, pc for ins_illegal, 0 otherwise.
  - MPIE ← MIE; MIE ← 0.
  - flush=1, stall=1, taken=0.
  - The trapping instruction's CSR write is suppressed.
  - Next state: TRAP.
- State TRAP:
  - taken=1, stall=0.
  - target = {mtvec[XLEN-1:2],2'b00}.
  - If mtvec[1:0]==1 and the trap was an interrupt, target also adds 4×(mcause code).
  - Next state: RUN. valid is ignored.
- mret in RUN, valid=1, no trap:
  - MIE ← MPIE; MPIE ← 1.
  - taken=1, target=mepc. This is combinational, with no extra state.
- CSR write (valid=1, no trap) updates the register at the clock edge. Reads reflect the old value in the same cycle.
- mret and a csr_we to mepc in the same cycle: mret uses the old mepc.

## Timing
- FSM has two states: RUN (reset) and TRAP.
- Branch/jump/mret redirect: 0-cycle latency, combinational from inputs.
- Trap redirect: flush in cycle N, taken/target in cycle N+1. Trap entry costs exactly one bubble cycle.
- Reset values:
  - state RUN.
  - MIE=0, MPIE=0, mie=0.
  - mtvec=MTVEC_RESET.
  - mepc=0, mcause=0, mtval=0.
  - Outputs taken/flush/stall = 0.
- Reset asserted mid-TRAP returns to RUN with no redirect.
- An irq dropping in cycle N after being sampled does not cancel entry.
- Simultaneous interrupt and exception: the interrupt wins. mepc is the pc of the un-executed instruction.

## Structure
- Shared package jump_pkg:
  - BASE_SRC_*, COND_* encodings (reused from jump.vh).
  - TRAP_* exception codes.
  - CSR address constants.
  - IRQ_CAUSE_BASE=16.
  - FSM state typedef.
- One sub-module, trap_prio: combinational priority encoder producing trap, cause, is_irq from the flags, irq, and mie.

## Test plan
- cond=COND_EQ_ZERO, alu_zero=1, pc=0x100, imm=0x20 → taken=1, target=0x120, same cycle, no flush.
- valid with ecall, pc=0x200, mtvec=0x1000 → cycle N: flush=1. Cycle N+1: taken=1, target=0x1000. Then mcause=11, mepc=0x200, MIE=0.
- MIE=1, mie[16]=1, irq[0]=1, ins_illegal asserted, mtvec=0x1001 → mcause=0x80000010, target=0x1040, mepc=pc.
- Trap handler mret with mepc=0x204, MPIE=1 → taken=1, target=0x204, MIE=1 same-edge.
- store_misalign with bad_addr=0x3003 plus csr_we to mtvec → mtval=0x3003, mtvec unchanged.
- rst_n pulled low in TRAP → no taken, state RUN, all CSRs at reset values.
